bp_io_req_tracker: RTL and testbench

BP_IO_REQ_TRACKER -- requirements
Module: bp_io_req_tracker

---
 rtl/bp_io_req_tracker.sv | 130 +++++++++++++
 tb/tb_bp_io_req_tracker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_io_req_tracker.sv
// ---------------------------------------------------------------------------
// bp_io_req_tracker: tracks in-flight IO commands between core and host,
// with drain control, response watchdog and spurious-response filtering.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bp_io_req_tracker #(
  parameter int msg_width_p       = 128,
  parameter int max_outstanding_p = 32,
  parameter int timeout_p         = 1024
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,

  input  logic [msg_width_p-1:0]                 cmd_i,
  input  logic                                   cmd_v_i,
  output logic                                   cmd_ready_and_o,

  output logic [msg_width_p-1:0]                 io_cmd_o,
  output logic                                   io_cmd_v_o,
  input  logic                                   io_cmd_ready_and_i,

  input  logic [msg_width_p-1:0]                 io_resp_i,
  input  logic                                   io_resp_v_i,
  output logic                                   io_resp_yumi_o,

  output logic [msg_width_p-1:0]                 resp_o,
  output logic                                   resp_v_o,
  input  logic                                   resp_yumi_i,

  input  logic                                   drain_i,
  output logic                                   drained_o,
  output logic                                   timeout_o,
  output logic                                   spurious_o,
  output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o
);

  localparam int cnt_w_lp   = $clog2(max_outstanding_p+1);
  localparam int timer_w_lp = $clog2(timeout_p+1);
  localparam logic [cnt_w_lp-1:0]   cnt_max_lp    = cnt_w_lp'(max_outstanding_p);
  localparam logic [timer_w_lp-1:0] timer_last_lp = timer_w_lp'(timeout_p-1);
  localparam logic [timer_w_lp-1:0] timer_max_lp  = timer_w_lp'(timeout_p);

  typedef enum logic [1:0] {
    READY = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2,
    ERROR = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [cnt_w_lp-1:0]     count_q, count_d;
  logic [timer_w_lp-1:0]   timer_q, timer_d;
  logic                    timeout_q, timeout_d;

  logic accept, busy, cmd_hs, inc, dec, expire;

  // Gating with reset_i keeps command valid and spurious pulses quiet while in reset.
  assign accept          = reset_i & (state_q == READY);
  assign busy            = (count_q != '0);

  assign io_cmd_o        = cmd_i;
  assign io_cmd_v_o      = cmd_v_i & accept;
  assign cmd_ready_and_o = io_cmd_ready_and_i & accept;

  assign resp_o          = io_resp_i;
  assign resp_v_o        = io_resp_v_i & busy;
  assign io_resp_yumi_o  = busy ? resp_yumi_i : io_resp_v_i;
  assign spurious_o      = reset_i & io_resp_v_i & ~busy;

  assign cmd_hs          = io_cmd_v_o & io_cmd_ready_and_i;
  assign inc             = cmd_hs & (count_q != cnt_max_lp);
  assign dec             = resp_yumi_i & busy;
  assign expire          = busy & ~resp_yumi_i & (timer_q == timer_last_lp);

  assign drained_o       = (state_q == DRAIN) & ~busy;
  assign timeout_o       = timeout_q;
  assign outstanding_o   = count_q;

  always_comb begin
    count_d = count_q;
    if (inc & ~dec) begin
      count_d = count_q + cnt_w_lp'(1);
    end else if (dec & ~inc) begin
      count_d = count_q - cnt_w_lp'(1);
    end

    timer_d = timer_q;
    if (!busy || resp_yumi_i) begin
      timer_d = '0;
    end else if (timer_q != timer_max_lp) begin
      timer_d = timer_q + timer_w_lp'(1);
    end

    timeout_d = timeout_q | expire;

    state_d = state_q;
    if (expire) begin
      state_d = ERROR;
    end else begin
      case (state_q)
        READY:   if (drain_i) state_d = DRAIN;
                 else if (count_d == cnt_max_lp) state_d = FULL;
        FULL:    if (drain_i) state_d = DRAIN;
                 else if (count_d < cnt_max_lp) state_d = READY;
        DRAIN:   if (!drain_i) state_d = (count_d == cnt_max_lp) ? FULL : READY;
        ERROR:   state_d = ERROR;
        default: state_d = READY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= READY;
      count_q   <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bp_io_req_tracker.sv
// ---------------------------------------------------------------------------
// tb_bp_io_req_tracker: scoreboard bench with directed scenarios and random
// traffic checked against a count/mode reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bp_io_req_tracker;

  localparam int MW   = 16;
  localparam int MAXO = 4;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [MW-1:0] cmd_i, io_cmd_o, io_resp_i, resp_o;
  logic          cmd_v_i, cmd_ready_and_o, io_cmd_v_o, io_cmd_ready_and_i;
  logic          io_resp_v_i, io_resp_yumi_o, resp_v_o, resp_yumi_i;
  logic          drain_i, drained_o, timeout_o, spurious_o;
  logic [2:0]    outstanding_o;

  bp_io_req_tracker #(
    .msg_width_p(MW), .max_outstanding_p(MAXO), .timeout_p(TO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_i(cmd_i), .cmd_v_i(cmd_v_i), .cmd_ready_and_o(cmd_ready_and_o),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_and_i(io_cmd_ready_and_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
    .resp_o(resp_o), .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
    .drain_i(drain_i), .drained_o(drained_o), .timeout_o(timeout_o),
    .spurious_o(spurious_o), .outstanding_o(outstanding_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: in-flight count, last-cycle drain request, watchdog age, sticky error.
  int m_cnt   = 0;
  int m_timer = 0;
  bit m_drain = 1'b0;
  bit m_to    = 1'b0;
  bit rdrain  = 1'b0;

  logic [MW-1:0] cmd_q[$];
  logic [MW-1:0] resp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit cv, input bit cr, input bit rv, input bit ry, input bit dr);
    bit acc, hs, dec;
    @(negedge clk);
    cmd_v_i            = cv;
    io_cmd_ready_and_i = cr;
    io_resp_v_i        = rv;
    resp_yumi_i        = ry & rv & (m_cnt > 0);
    drain_i            = dr;
    cmd_i              = MW'($urandom);
    io_resp_i          = MW'($urandom);
    #1;
    acc = !m_to && !m_drain && (m_cnt < MAXO);
    hs  = cv && cr && acc;
    dec = resp_yumi_i;
    chk("cmd_ready",    cmd_ready_and_o, cr && acc);
    chk("io_cmd_v",     io_cmd_v_o,      cv && acc);
    chk("resp_v",       resp_v_o,        rv && (m_cnt > 0));
    chk("io_resp_yumi", io_resp_yumi_o,  (m_cnt > 0) ? resp_yumi_i : rv);
    chk("spurious",     spurious_o,      rv && (m_cnt == 0));
    chk("outstanding",  outstanding_o,   m_cnt);
    chk("drained",      drained_o,       !m_to && m_drain && (m_cnt == 0));
    chk("timeout",      timeout_o,       m_to);
    if (hs)  cmd_q.push_back(cmd_i);
    if (dec) resp_q.push_back(io_resp_i);
    @(posedge clk);
    if (m_cnt != 0 && !dec && m_timer == TO-1) m_to = 1'b1;
    if (m_cnt == 0 || dec) m_timer = 0;
    else if (m_timer < TO) m_timer++;
    m_cnt   = m_cnt + int'(hs) - int'(dec);
    m_drain = dr;
    chk("cmd_q_consumed",  cmd_q.size(),  0);
    chk("resp_q_consumed", resp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i            = 1'b0;
    cmd_v_i            = 1'b1;
    io_cmd_ready_and_i = 1'b1;
    io_resp_v_i        = 1'b1;
    resp_yumi_i        = 1'b0;
    drain_i            = 1'b0;
    #1;
    chk("rst_io_cmd_v",    io_cmd_v_o,    0);
    chk("rst_resp_v",      resp_v_o,      0);
    chk("rst_spurious",    spurious_o,    0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_timeout",     timeout_o,     0);
    chk("rst_drained",     drained_o,     0);
    @(negedge clk);
    reset_i            = 1'b1;
    cmd_v_i            = 1'b0;
    io_cmd_ready_and_i = 1'b0;
    io_resp_v_i        = 1'b0;
    m_cnt   = 0;
    m_timer = 0;
    m_drain = 1'b0;
    m_to    = 1'b0;
    rdrain  = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes a transfer.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (io_cmd_v_o && io_cmd_ready_and_i) begin
        if (cmd_q.size() == 0) chk("cmd_unexpected", io_cmd_v_o, 0);
        else chk("cmd_data", io_cmd_o, cmd_q.pop_front());
      end
      if (resp_v_o && resp_yumi_i) begin
        if (resp_q.size() == 0) chk("resp_unexpected", resp_v_o, 0);
        else chk("resp_data", resp_o, resp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit: actual=limit_reached required=finish");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b0; cmd_i = '0; cmd_v_i = 1'b0; io_cmd_ready_and_i = 1'b0;
    io_resp_i = '0; io_resp_v_i = 1'b0; resp_yumi_i = 1'b0; drain_i = 1'b0;

    // Fill to capacity with back-to-back commands.
    do_reset();
    repeat (5) step(1, 1, 0, 0, 0);
    #1;
    chk("full_count", outstanding_o, 4);
    chk("full_ready", cmd_ready_and_o, 0);

    step(0, 1, 1, 1, 0);
    #1;
    chk("unfull_count", outstanding_o, 3);
    chk("unfull_ready", cmd_ready_and_o, 1);

    step(0, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    #1;
    chk("simul_cmd_resp_count", outstanding_o, 2);

    // Response with nothing outstanding.
    do_reset();
    step(0, 0, 1, 0, 0);
    #1;
    chk("spur_pulse", spurious_o, 1);
    chk("spur_selfyumi", io_resp_yumi_o, 1);
    step(0, 0, 0, 0, 0);
    #1;
    chk("spur_clear", spurious_o, 0);

    // Watchdog with one command left unanswered.
    do_reset();
    step(1, 1, 0, 0, 0);
    repeat (7) step(0, 0, 0, 0, 0);
    #1;
    chk("to_early", timeout_o, 0);
    step(0, 0, 0, 0, 0);
    #1;
    chk("to_set", timeout_o, 1);
    step(1, 1, 0, 0, 0);
    #1;
    chk("to_blocked", cmd_ready_and_o, 0);
    step(0, 0, 1, 1, 0);
    #1;
    chk("to_late_count", outstanding_o, 0);
    chk("to_sticky", timeout_o, 1);

    // Drain with three outstanding.
    do_reset();
    repeat (3) step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 1, 1, 1);
    #1;
    chk("drain_done", drained_o, 1);
    step(0, 1, 0, 0, 0);
    #1;
    chk("drain_exit_ready", cmd_ready_and_o, 1);
    chk("drain_exit_drained", drained_o, 0);

    // Random traffic with occasional mid-stream resets and drain toggles.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 2) begin
        do_reset();
      end else begin
        if ($urandom_range(99) < 4) rdrain = ~rdrain;
        step($urandom_range(99) < 50, $urandom_range(99) < 70,
             $urandom_range(99) < 45, $urandom_range(99) < 75, rdrain);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
